// File: rtl/ledr_pkg.sv
// Shared constants and helpers for the LEDR PWM / pulse-stretch driver.
package ledr_pkg;

  localparam int LEDR_WIDTH = 10;
  localparam int PWM_BITS   = 4;

  localparam logic [PWM_BITS-1:0] DUTY_OFF  = '0;
  localparam logic [PWM_BITS-1:0] DUTY_FULL = '1;

  // Counter width able to hold the value hold_ticks itself.
  function automatic int stretch_width(input int hold_ticks);
    return $clog2(hold_ticks + 1);
  endfunction

endpackage

// File: rtl/ledr_stretch.sv
// Per-LED pulse stretcher: a rising edge keeps the LED lit for at least
// HOLD_TICKS PWM ticks, retriggering on every new edge.
module ledr_stretch
  import ledr_pkg::*;
#(
  parameter int HOLD_TICKS = 2048
) (
  input  logic clk,
  input  logic reset_n,
  input  logic rise,
  input  logic tick,
  output logic active
);

  localparam int CW = stretch_width(HOLD_TICKS);

  logic [CW-1:0] cnt;

  // A new edge reloads even when a tick lands in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= CW'(HOLD_TICKS);
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign active = (cnt != '0);

endmodule

// File: rtl/ledr_pwm_driver.sv
// LEDR pin driver: global PWM brightness plus per-bit pulse stretching,
// placed between the LED PIO output register and the board pins.
module ledr_pwm_driver
  import ledr_pkg::*;
#(
  parameter int WIDTH        = LEDR_WIDTH,
  parameter int PRESCALE     = 50,
  parameter int PWM_BITS     = 4,
  parameter int DEFAULT_DUTY = 8,
  parameter int HOLD_TICKS   = 2048
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [WIDTH-1:0]    led_in,
  input  logic [PWM_BITS-1:0] duty,
  output logic [WIDTH-1:0]    led_out,
  output logic                pwm_sync
);

  localparam int                  PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MIN = PWM_BITS'(DUTY_OFF);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

  logic [WIDTH-1:0]    led_q;
  logic [WIDTH-1:0]    led_d;
  logic [WIDTH-1:0]    rise;
  logic [WIDTH-1:0]    active;
  logic [PS_W-1:0]     prescale_cnt;
  logic [PWM_BITS-1:0] phase;
  logic [PWM_BITS-1:0] duty_q;
  logic                tick;
  logic                wrap;
  logic                pwm_on;

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_q <= '0;
      led_d <= '0;
    end else begin
      led_q <= led_in;
      led_d <= led_q;
    end
  end

  assign rise = led_q & ~led_d;
  assign tick = (prescale_cnt == PS_LAST);
  assign wrap = tick && (phase == DUTY_MAX);

  // Shared timebase; duty is only accepted at a period boundary so a
  // period never mixes two brightness levels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescale_cnt <= '0;
      phase        <= '0;
      duty_q       <= PWM_BITS'(DEFAULT_DUTY);
    end else begin
      prescale_cnt <= tick ? '0 : prescale_cnt + PS_W'(1);
      if (tick) begin
        phase <= phase + PWM_BITS'(1);
      end
      if (wrap) begin
        duty_q <= duty;
      end
    end
  end

  // NOTE: pwm_on is defaulted before the decision so no branch leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    pwm_on = 1'b0;
    if (duty_q == DUTY_MIN) begin
      pwm_on = 1'b0;
    end else if (duty_q == DUTY_MAX) begin
      pwm_on = 1'b1;
    end else begin
      pwm_on = (phase < duty_q);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_stretch
    ledr_stretch #(
      .HOLD_TICKS(HOLD_TICKS)
    ) u_stretch (
      .clk    (clk),
      .reset_n(reset_n),
      .rise   (rise[i]),
      .tick   (tick),
      .active (active[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_out  <= '0;
      pwm_sync <= 1'b0;
    end else begin
      led_out  <= (led_q & {WIDTH{pwm_on}}) | active;
      pwm_sync <= wrap;
    end
  end

endmodule

// File: tb/tb_ledr_pwm_driver.sv
// Self-checking bench for ledr_pwm_driver: cycle scoreboard against a
// behavioural model, a duty table, and hand-written corner sequences.
module tb_ledr_pwm_driver;

  localparam int W            = ledr_pkg::LEDR_WIDTH;
  localparam int PRESCALE     = 2;
  localparam int PB           = 4;
  localparam int HOLD_TICKS   = 3;
  localparam int DEFAULT_DUTY = 8;

  logic          clk      = 1'b0;
  logic          reset_n  = 1'b0;
  logic [W-1:0]  led_in   = '0;
  logic [PB-1:0] duty     = '0;
  logic [W-1:0]  led_out;
  logic          pwm_sync;

  int checks = 0;
  int errors = 0;

  ledr_pwm_driver #(
    .WIDTH       (W),
    .PRESCALE    (PRESCALE),
    .PWM_BITS    (PB),
    .DEFAULT_DUTY(DEFAULT_DUTY),
    .HOLD_TICKS  (HOLD_TICKS)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .led_in  (led_in),
    .duty    (duty),
    .led_out (led_out),
    .pwm_sync(pwm_sync)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [W-1:0] led;
    logic         sync;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] m_q, m_d;
  int           m_pre, m_phase, m_duty;
  int           m_st[W];

  // Reference model: advances on each clock, pushes the output the DUT
  // must show after that edge.
  initial forever begin
    logic         on, tk, wr;
    logic [W-1:0] rise_m, held;
    exp_t         e;
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_q = '0; m_d = '0; m_pre = 0; m_phase = 0; m_duty = DEFAULT_DUTY;
      for (int i = 0; i < W; i++) m_st[i] = 0;
      exp_q.delete();
    end else begin
      rise_m = m_q & ~m_d;
      tk = (m_pre == PRESCALE - 1);
      wr = tk && (m_phase == 15);
      if (m_duty == 0) on = 1'b0;
      else if (m_duty == 15) on = 1'b1;
      else on = (m_phase < m_duty);
      held = '0;
      for (int i = 0; i < W; i++) if (m_st[i] > 0) held[i] = 1'b1;
      e.led  = (on ? m_q : '0) | held;
      e.sync = wr;
      for (int i = 0; i < W; i++) begin
        if (rise_m[i]) m_st[i] = HOLD_TICKS;
        else if (tk && m_st[i] > 0) m_st[i] = m_st[i] - 1;
      end
      m_pre = tk ? 0 : m_pre + 1;
      if (wr) m_duty = int'(duty);
      if (tk) m_phase = (m_phase + 1) % 16;
      m_d = m_q;
      m_q = led_in;
      exp_q.push_back(e);
    end
  end

  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (reset_n && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("sb_led_out", 32'(led_out), 32'(e.led));
      check("sb_pwm_sync", 32'(pwm_sync), 32'(e.sync));
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sync();
    int n = 0;
    do begin
      step();
      n++;
    end while (!pwm_sync && n < 80);
    if (!pwm_sync) check("sync_timeout", 32'd0, 32'd1);
  endtask

  // Single-clk pulse on mask at k=0, optional second pulse after sample k=second_at.
  task automatic run_pulse(input logic [W-1:0] mask, input int second_at,
                           output int first, output int len, output int gaps);
    logic prev = 1'b0;
    first = -1; len = 0; gaps = 0;
    led_in = mask;
    for (int k = 1; k <= 20; k++) begin
      step();
      if ((led_out & mask) != '0) begin
        if (first < 0) first = k;
        else if (!prev) gaps++;
        len++;
        prev = 1'b1;
      end else begin
        prev = 1'b0;
      end
      led_in = (k == second_at) ? mask : '0;
    end
  endtask

  // ---------------- duty table ----------------
  typedef struct {
    logic [PB-1:0] duty;
    logic [W-1:0]  led;
    int            exp_cnt;
    int            exp_first;
  } vec_t;

  vec_t vecs[6];

  int bad, wide, nsync, last, n, cnt, first, stray, len, gaps;
  logic prev_s;

  initial begin
    vecs[0] = '{duty: 4'd15, led: 10'h3FF, exp_cnt: 32, exp_first: 0};
    vecs[1] = '{duty: 4'd4,  led: 10'h001, exp_cnt: 8,  exp_first: 1};
    vecs[2] = '{duty: 4'd0,  led: 10'h155, exp_cnt: 0,  exp_first: -1};
    vecs[3] = '{duty: 4'd1,  led: 10'h2AA, exp_cnt: 2,  exp_first: 1};
    vecs[4] = '{duty: 4'd14, led: 10'h00F, exp_cnt: 28, exp_first: 1};
    vecs[5] = '{duty: 4'd8,  led: 10'h3C0, exp_cnt: 16, exp_first: 1};

    // Reset behaviour
    reset_n = 1'b0;
    led_in  = 10'h3FF;
    repeat (4) begin
      step();
      check("rst_led_out", 32'(led_out), 32'd0);
      check("rst_pwm_sync", 32'(pwm_sync), 32'd0);
    end
    led_in  = '0;
    reset_n = 1'b1;
    bad = 0; wide = 0; nsync = 0; last = -1; prev_s = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (led_out != '0) bad++;
      if (pwm_sync) begin
        if (prev_s) wide++;
        if (last < 0) check("sync_first", 32'(i), 32'd32);
        else check("sync_period", 32'(i - last), 32'd32);
        last = i;
        nsync++;
      end
      prev_s = pwm_sync;
    end
    check("idle_led_out", 32'(bad), 32'd0);
    check("sync_count", 32'(nsync), 32'd3);
    check("sync_width", 32'(wide), 32'd0);

    // Full brightness: 2 clk latency, then steady
    duty = ledr_pkg::DUTY_FULL;
    wait_sync();
    wait_sync();
    led_in = 10'h3FF;
    step();
    check("full_lat1", 32'(led_out), 32'd0);
    step();
    check("full_lat2", 32'(led_out), 32'h3FF);
    bad = 0;
    repeat (40) begin
      step();
      if (led_out != 10'h3FF) bad++;
    end
    check("full_steady", 32'(bad), 32'd0);

    // Duty table: one full period counted from pwm_sync
    foreach (vecs[v]) begin
      led_in = vecs[v].led;
      duty   = vecs[v].duty;
      wait_sync();
      wait_sync();
      cnt = 0; first = -1; stray = 0;
      for (int k = 0; k < 32; k++) begin
        if (k > 0) step();
        if (led_out == vecs[v].led) begin
          cnt++;
          if (first < 0) first = k;
        end else if (led_out != '0) begin
          stray++;
        end
      end
      check("duty_on_count", 32'(cnt), 32'(vecs[v].exp_cnt));
      check("duty_first_on", 32'(first), 32'(vecs[v].exp_first));
      check("duty_stray_bits", 32'(stray), 32'd0);
    end

    // Pulse stretch at duty 0, then retrigger inside the hold window
    led_in = '0;
    duty   = 4'd0;
    wait_sync();
    wait_sync();
    run_pulse(10'h200, -1, first, len, gaps);
    check("stretch_first", 32'(first), 32'd3);
    check("stretch_len_5_or_6", 32'(len == 5 || len == 6), 32'd1);
    check("stretch_gaps", 32'(gaps), 32'd0);
    check("stretch_end", 32'(led_out), 32'd0);
    run_pulse(10'h200, 4, first, len, gaps);
    check("retrig_first", 32'(first), 32'd3);
    check("retrig_len_9_or_10", 32'(len == 9 || len == 10), 32'd1);
    check("retrig_gaps", 32'(gaps), 32'd0);

    // Duty change mid-period: old duty holds until the next period
    led_in = 10'h00F;
    duty   = 4'd15;
    wait_sync();
    wait_sync();
    repeat (10) step();
    duty = 4'd0;
    bad = 0; n = 0;
    do begin
      step();
      n++;
      if (led_out != 10'h00F) bad++;
    end while (!pwm_sync && n < 40);
    check("midchange_hold", 32'(bad), 32'd0);
    check("midchange_sync_at", 32'(n), 32'd22);
    step();
    check("midchange_off", 32'(led_out), 32'd0);

    // Reset while a stretch counter is running
    led_in = '0;
    repeat (8) step();
    led_in = 10'h001;
    step();
    led_in = '0;
    repeat (3) step();
    check("prereset_stretch", 32'(led_out), 32'h001);
    #3 reset_n = 1'b0;
    #1;
    check("async_rst_led_out", 32'(led_out), 32'd0);
    check("async_rst_pwm_sync", 32'(pwm_sync), 32'd0);
    step();
    step();
    check("rst_hold_led_out", 32'(led_out), 32'd0);
    reset_n = 1'b1;
    bad = 0;
    repeat (20) begin
      step();
      if (led_out != '0) bad++;
    end
    check("no_stretch_resume", 32'(bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
